rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0: extra ROM access cycles inserted before capture (0..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port m0_req, input, 1: requester 0 (instruction fetch) read request, level, held until m0_valid seen.
REQ-005 SHALL have port m0_addr, input, 32: requester 0 byte address.
REQ-006 SHALL have port m0_rdata, output, 32: requester 0 read data.
REQ-007 SHALL have port m0_valid, output, 1: requester 0 response strobe.
REQ-008 SHALL have ports m1_req, m1_addr, m1_rdata, m1_valid with identical widths and meanings for requester 1 (data load).
REQ-009 SHALL have port rom_addr, output, 32: registered byte address to the shared combinational ROM.
REQ-010 SHALL have port rom_data, input, 32: ROM read data, already offset-shifted by the ROM.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-013 In IDLE with any mN_req high, SHALL grant one requester, latch its address into rom_addr, load wait counter with WAIT_CYCLES, and go to ACCESS.
REQ-014 In IDLE with no request, SHALL stay in IDLE; rom_addr holds its last value.
REQ-015 On simultaneous m0_req and m1_req in IDLE, SHALL grant the requester not granted last (round-robin via a 1-bit last_grant register updated at each grant).
REQ-016 In ACCESS with counter nonzero, SHALL decrement counter and stay in ACCESS.
REQ-017 In ACCESS with counter zero, SHALL capture rom_data into the granted requester's rdata, set its valid, and go to RESP.
REQ-018 In RESP, SHALL hold valid high for exactly that one cycle, then clear it and go to IDLE.
REQ-019 Latency: req high before edge N -> valid high during the cycle after edge N+1+WAIT_CYCLES; a back-to-back request is granted no earlier than the edge after RESP.
REQ-020 mN_addr SHALL be sampled only at grant; later changes SHALL not affect the access in progress.
REQ-021 Request dropped before grant SHALL cause no access; request dropped after grant SHALL still complete and still pulse valid.
REQ-022 Only the granted requester's rdata SHALL change; the other rdata SHALL hold its previous value.
REQ-023 m0_valid and m1_valid SHALL never be high in the same cycle.
REQ-024 A request arriving while busy SHALL wait and be granted in the next IDLE cycle; no request is lost while held.

Reset
REQ-025 On rst_n low, asynchronously and regardless of state: state=IDLE, counter=0, last_grant=1 (m0 wins first tie), rom_addr=0, m0_rdata=m1_rdata=0, m0_valid=m1_valid=0, busy=0.
REQ-026 Reset mid-ACCESS or mid-RESP SHALL abort the access with no valid pulse; after release, held requests are re-arbitrated from IDLE.

Verification
REQ-027 WAIT_CYCLES=0, ROM model data=addr^32'hA5A5_0000; m0_req with m0_addr=32'h0000_0010 -> rom_addr=32'h10 after grant edge, m0_valid one cycle with m0_rdata=32'hA5A5_0010, 2 cycles after request edge.
REQ-028 m0_req and m1_req raised same cycle after reset, addresses 32'h4 and 32'h8 -> m0 served first (rdata 32'hA5A5_0004), then m1 (32'hA5A5_0008); next tie serves m1 first.
REQ-029 WAIT_CYCLES=3; m1_req addr 32'h20 -> m1_valid exactly 5 cycles after request edge, busy high 4 cycles prior and during RESP.
REQ-030 m0_addr changed from 32'h10 to 32'h14 one cycle after grant -> m0_rdata=32'hA5A5_0010; m1_rdata unchanged throughout.
REQ-031 rst_n pulsed low during ACCESS with m1_req held -> no valid pulse, all outputs zero immediately, m1 re-granted on first IDLE edge after release.
REQ-032 Continuous m0_req and m1_req for 20 cycles -> grants strictly alternate, valids never overlap, each valid exactly one cycle.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Shared-ROM arbiter bus: two read requesters, the ROM address/data pair and
// the arbiter busy flag. The arbiter connects through the slave modport; the
// requesters and the ROM model sit on the master side.
interface rom_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_rdata;
    logic        m0_valid;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_rdata;
    logic        m1_valid;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        busy;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_addr, rom_data,
        output m0_rdata, m0_valid, m1_rdata, m1_valid, rom_addr, busy
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_addr, rom_data,
        input  m0_rdata, m0_valid, m1_rdata, m1_valid, rom_addr, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between an instruction
// fetch port (m0) and a data load port (m1). Each access walks
// IDLE -> ACCESS (WAIT_CYCLES extra cycles) -> RESP, with a one-cycle valid.
module rom_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    // 0 = m0, 1 = m1; during ACCESS this is also the current owner.
    logic        last_grant_q, last_grant_d;
    logic        grant_sel;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m0_valid_q, m0_valid_d;
    logic        m1_valid_q, m1_valid_d;

    // Next-state, arbitration and capture logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rom_addr_d   = rom_addr_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_valid_d   = 1'b0;
        m1_valid_d   = 1'b0;
        grant_sel    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // On a tie, serve whoever was not served last.
                    grant_sel    = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
                    last_grant_d = grant_sel;
                    rom_addr_d   = grant_sel ? bus.m1_addr : bus.m0_addr;
                    cnt_d        = 4'(WAIT_CYCLES);
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (last_grant_q) begin
                        m1_rdata_d = bus.rom_data;
                        m1_valid_d = 1'b1;
                    end else begin
                        m0_rdata_d = bus.rom_data;
                        m0_valid_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                // Valid defaults low, so the pulse ends as we return to IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            rom_addr_q   <= 32'd0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
            m0_valid_q   <= 1'b0;
            m1_valid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rom_addr_q   <= rom_addr_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_valid_q   <= m0_valid_d;
            m1_valid_q   <= m1_valid_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m0_valid = m0_valid_q;
    assign bus.m1_valid = m1_valid_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter. Two instances share clock and reset:
// dut0 with WAIT_CYCLES=0 and dut3 with WAIT_CYCLES=3. Each ROM model returns
// addr ^ 32'hA5A5_0000. Inputs change and outputs are sampled on the falling
// edge, away from the rising edge the design uses.
module tb_rom_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rom_arbiter_if bus0 ();
    rom_arbiter_if bus3 ();

    assign bus0.rom_data = bus0.rom_addr ^ 32'hA5A5_0000;
    assign bus3.rom_data = bus3.rom_addr ^ 32'hA5A5_0000;

    rom_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    rom_arbiter #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        vectors++; if (bus0.rom_addr !== 32'h0) begin miscompares++; $display("FAIL reset_rom_addr: got %h want 0", bus0.rom_addr); end
        vectors++; if (bus0.m0_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_m0_rdata: got %h want 0", bus0.m0_rdata); end
        vectors++; if (bus0.m1_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_m1_rdata: got %h want 0", bus0.m1_rdata); end
        vectors++; if (bus0.m0_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m0_valid: got %b want 0", bus0.m0_valid); end
        vectors++; if (bus0.m1_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m1_valid: got %b want 0", bus0.m1_valid); end
        rst_n = 1'b1;
    endtask

    // Single m0 read, WAIT_CYCLES=0: valid two edges after the request edge.
    task automatic test_single();
        @(negedge clk);
        bus0.m0_addr = 32'h0000_0010;
        bus0.m0_req  = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", bus0.busy); end
        vectors++; if (bus0.rom_addr !== 32'h10) begin miscompares++; $display("FAIL single_rom_addr: got %h want 00000010", bus0.rom_addr); end
        vectors++; if (bus0.m0_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b want 0", bus0.m0_valid); end
        @(negedge clk);
        vectors++; if (bus0.m0_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bus0.m0_valid); end
        vectors++; if (bus0.m0_rdata !== 32'hA5A5_0010) begin miscompares++; $display("FAIL single_rdata: got %h want a5a50010", bus0.m0_rdata); end
        vectors++; if (bus0.m1_valid !== 1'b0) begin miscompares++; $display("FAIL single_m1_valid: got %b want 0", bus0.m1_valid); end
        vectors++; if (bus0.m1_rdata !== 32'h0) begin miscompares++; $display("FAIL single_m1_rdata: got %h want 0", bus0.m1_rdata); end
        bus0.m0_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus0.m0_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_len: got %b want 0", bus0.m0_valid); end
        vectors++; if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b want 0", bus0.busy); end
    endtask

    // Tie after reset goes to m0; m0 keeps requesting, so the next tie goes to m1.
    task automatic test_tie();
        do_reset();
        bus0.m0_addr = 32'h4;
        bus0.m1_addr = 32'h8;
        bus0.m0_req  = 1'b1;
        bus0.m1_req  = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.rom_addr !== 32'h4) begin miscompares++; $display("FAIL tie1_rom_addr: got %h want 00000004", bus0.rom_addr); end
        @(negedge clk);
        vectors++; if (bus0.m0_valid !== 1'b1) begin miscompares++; $display("FAIL tie1_m0_valid: got %b want 1", bus0.m0_valid); end
        vectors++; if (bus0.m1_valid !== 1'b0) begin miscompares++; $display("FAIL tie1_m1_valid: got %b want 0", bus0.m1_valid); end
        vectors++; if (bus0.m0_rdata !== 32'hA5A5_0004) begin miscompares++; $display("FAIL tie1_m0_rdata: got %h want a5a50004", bus0.m0_rdata); end
        @(negedge clk);
        vectors++; if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL tie_gap_busy: got %b want 0", bus0.busy); end
        @(negedge clk);
        vectors++; if (bus0.rom_addr !== 32'h8) begin miscompares++; $display("FAIL tie2_rom_addr: got %h want 00000008", bus0.rom_addr); end
        @(negedge clk);
        vectors++; if (bus0.m1_valid !== 1'b1) begin miscompares++; $display("FAIL tie2_m1_valid: got %b want 1", bus0.m1_valid); end
        vectors++; if (bus0.m0_valid !== 1'b0) begin miscompares++; $display("FAIL tie2_m0_valid: got %b want 0", bus0.m0_valid); end
        vectors++; if (bus0.m1_rdata !== 32'hA5A5_0008) begin miscompares++; $display("FAIL tie2_m1_rdata: got %h want a5a50008", bus0.m1_rdata); end
        vectors++; if (bus0.m0_rdata !== 32'hA5A5_0004) begin miscompares++; $display("FAIL tie2_m0_hold: got %h want a5a50004", bus0.m0_rdata); end
        bus0.m0_req = 1'b0;
        bus0.m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Address changes after grant must not reach the access in flight.
    task automatic test_addr_change();
        bus0.m0_addr = 32'h10;
        bus0.m0_req  = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.rom_addr !== 32'h10) begin miscompares++; $display("FAIL addr_grant: got %h want 00000010", bus0.rom_addr); end
        bus0.m0_addr = 32'h14;
        @(negedge clk);
        vectors++; if (bus0.m0_rdata !== 32'hA5A5_0010) begin miscompares++; $display("FAIL addr_rdata: got %h want a5a50010", bus0.m0_rdata); end
        vectors++; if (bus0.rom_addr !== 32'h10) begin miscompares++; $display("FAIL addr_hold: got %h want 00000010", bus0.rom_addr); end
        vectors++; if (bus0.m1_rdata !== 32'hA5A5_0008) begin miscompares++; $display("FAIL addr_m1_hold: got %h want a5a50008", bus0.m1_rdata); end
        bus0.m0_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus0.m1_rdata !== 32'hA5A5_0008) begin miscompares++; $display("FAIL addr_m1_hold2: got %h want a5a50008", bus0.m1_rdata); end
    endtask

    // Drop after grant still completes; drop before grant never starts.
    task automatic test_drop();
        bus0.m1_addr = 32'h40;
        bus0.m1_req  = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.busy !== 1'b1) begin miscompares++; $display("FAIL drop_after_busy: got %b want 1", bus0.busy); end
        bus0.m1_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus0.m1_valid !== 1'b1) begin miscompares++; $display("FAIL drop_after_valid: got %b want 1", bus0.m1_valid); end
        vectors++; if (bus0.m1_rdata !== 32'hA5A5_0040) begin miscompares++; $display("FAIL drop_after_rdata: got %h want a5a50040", bus0.m1_rdata); end
        @(negedge clk);
        bus0.m0_addr = 32'h50;
        bus0.m0_req  = 1'b1;
        @(negedge clk);
        bus0.m1_addr = 32'h60;
        bus0.m1_req  = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.m0_valid !== 1'b1) begin miscompares++; $display("FAIL drop_before_m0_valid: got %b want 1", bus0.m0_valid); end
        bus0.m0_req = 1'b0;
        bus0.m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL drop_before_busy: got %b want 0", bus0.busy); end
        vectors++; if (bus0.m1_valid !== 1'b0) begin miscompares++; $display("FAIL drop_before_m1_valid: got %b want 0", bus0.m1_valid); end
        vectors++; if (bus0.m1_rdata !== 32'hA5A5_0040) begin miscompares++; $display("FAIL drop_before_m1_rdata: got %h want a5a50040", bus0.m1_rdata); end
    endtask

    // WAIT_CYCLES=3: four ACCESS cycles, then valid in the fifth cycle.
    task automatic test_wait3();
        bus3.m1_addr = 32'h20;
        bus3.m1_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (bus3.busy !== 1'b1) begin miscompares++; $display("FAIL wait3_busy[%0d]: got %b want 1", k, bus3.busy); end
            vectors++; if (bus3.m1_valid !== 1'b0) begin miscompares++; $display("FAIL wait3_early[%0d]: got %b want 0", k, bus3.m1_valid); end
        end
        @(negedge clk);
        vectors++; if (bus3.m1_valid !== 1'b1) begin miscompares++; $display("FAIL wait3_valid: got %b want 1", bus3.m1_valid); end
        vectors++; if (bus3.m1_rdata !== 32'hA5A5_0020) begin miscompares++; $display("FAIL wait3_rdata: got %h want a5a50020", bus3.m1_rdata); end
        vectors++; if (bus3.busy !== 1'b1) begin miscompares++; $display("FAIL wait3_resp_busy: got %b want 1", bus3.busy); end
        bus3.m1_req = 1'b0;
        @(negedge clk);
        vectors++; if (bus3.m1_valid !== 1'b0) begin miscompares++; $display("FAIL wait3_valid_len: got %b want 0", bus3.m1_valid); end
        vectors++; if (bus3.busy !== 1'b0) begin miscompares++; $display("FAIL wait3_idle: got %b want 0", bus3.busy); end
    endtask

    // Reset during ACCESS with m1 held: abort, clear at once, re-grant after release.
    task automatic test_reset_mid();
        bus0.m1_addr = 32'h30;
        bus0.m1_req  = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.busy !== 1'b1) begin miscompares++; $display("FAIL rmid_access: got %b want 1", bus0.busy); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (bus0.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", bus0.busy); end
        vectors++; if (bus0.rom_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_rom_addr: got %h want 0", bus0.rom_addr); end
        vectors++; if (bus0.m0_rdata !== 32'h0) begin miscompares++; $display("FAIL rmid_m0_rdata: got %h want 0", bus0.m0_rdata); end
        vectors++; if (bus0.m1_rdata !== 32'h0) begin miscompares++; $display("FAIL rmid_m1_rdata: got %h want 0", bus0.m1_rdata); end
        @(negedge clk);
        vectors++; if (bus0.m1_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_no_valid: got %b want 0", bus0.m1_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus0.rom_addr !== 32'h30) begin miscompares++; $display("FAIL rmid_regrant: got %h want 00000030", bus0.rom_addr); end
        @(negedge clk);
        vectors++; if (bus0.m1_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_valid: got %b want 1", bus0.m1_valid); end
        vectors++; if (bus0.m1_rdata !== 32'hA5A5_0030) begin miscompares++; $display("FAIL rmid_rdata: got %h want a5a50030", bus0.m1_rdata); end
        bus0.m1_req = 1'b0;
        @(negedge clk);
    endtask

    // Both requesters held for 20 cycles: a pulse every third cycle, m0 first, alternating.
    task automatic test_back_to_back();
        int   pulses;
        logic exp0;
        logic exp1;
        pulses = 0;
        do_reset();
        bus0.m0_addr = 32'h100;
        bus0.m1_addr = 32'h200;
        bus0.m0_req  = 1'b1;
        bus0.m1_req  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp0 = ((i % 3) == 2) && (((i / 3) % 2) == 0);
            exp1 = ((i % 3) == 2) && (((i / 3) % 2) == 1);
            vectors++; if (bus0.m0_valid !== exp0) begin miscompares++; $display("FAIL b2b_m0_valid[%0d]: got %b want %b", i, bus0.m0_valid, exp0); end
            vectors++; if (bus0.m1_valid !== exp1) begin miscompares++; $display("FAIL b2b_m1_valid[%0d]: got %b want %b", i, bus0.m1_valid, exp1); end
            vectors++; if (bus0.m0_valid === 1'b1 && bus0.m1_valid === 1'b1) begin miscompares++; $display("FAIL b2b_overlap[%0d]: got both valid want at most one", i); end
            if (bus0.m0_valid === 1'b1 || bus0.m1_valid === 1'b1) pulses++;
            if (exp0) begin
                vectors++; if (bus0.m0_rdata !== 32'hA5A5_0100) begin miscompares++; $display("FAIL b2b_m0_rdata[%0d]: got %h want a5a50100", i, bus0.m0_rdata); end
            end
            if (exp1) begin
                vectors++; if (bus0.m1_rdata !== 32'hA5A5_0200) begin miscompares++; $display("FAIL b2b_m1_rdata[%0d]: got %h want a5a50200", i, bus0.m1_rdata); end
            end
        end
        vectors++; if (pulses != 7) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 7", pulses); end
        bus0.m0_req = 1'b0;
        bus0.m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus0.m0_req  = 1'b0;
        bus0.m0_addr = 32'h0;
        bus0.m1_req  = 1'b0;
        bus0.m1_addr = 32'h0;
        bus3.m0_req  = 1'b0;
        bus3.m0_addr = 32'h0;
        bus3.m1_req  = 1'b0;
        bus3.m1_addr = 32'h0;

        test_reset();
        test_single();
        test_tie();
        test_addr_change();
        test_drop();
        test_wait3();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
